okand_serial_alu: RTL
=====================

Name: okand_serial_alu

Overview:
- Parametrised successor to the bit-serial operand/result engine on the PC link.
- Receives a serial frame from the PC: 2-bit opcode, operand A, operand B, all LSB first.
- Computes one of four operations, then streams the result back LSB first.
- Unlike the previous generation, it has a WIDTH parameter, an opcode field, reset, input ready and output backpressure.

Parameters:
- WIDTH, 16, operand and result width in bits; legal range 2..64.

Ports:
- pc_clk  input  1  sole clock; all logic on rising edge.
- pc_rst_n  input  1  asynchronous active-low reset.
- pc_data  input  1  serial input bit.
- pc_valid  input  1  pc_data is valid this cycle.
- pc_ready  output  1  block accepts input bits this cycle.
- fpga_data  output  1  serial result bit.
- fpga_valid  output  1  fpga_data is valid.
- fpga_ready  input  1  PC consumes fpga_data this cycle.
- busy  output  1  high in COMPUTE or SEND.

Behaviour:
- Reset (async assert, sync deassert by board logic):
  - State goes to RECV; bit counters, opcode, operands and result go to 0.
  - Outputs: pc_ready=1, fpga_valid=0, fpga_data=0, busy=0.
- Frame format: 2+2*WIDTH bits.
  - Bits 0-1: opcode, LSB first.
  - Bits 2..WIDTH+1: operand A[0..WIDTH-1].
  - Remaining bits: operand B[0..WIDTH-1].
- Input handshake: a bit is accepted on an edge where pc_valid && pc_ready. Each accepted bit advances rx_idx by 1.
  - pc_valid while pc_ready=0 is ignored: bit dropped, no counter change.
  - pc_valid low mid-frame is a stall, not an abort.
- State machine:
  - RECV: pc_ready=1. On acceptance of frame bit 2+2*WIDTH-1, go to COMPUTE and clear rx_idx.
  - COMPUTE: exactly one cycle. Register the result, clear tx_idx, go to SEND.
  - SEND: fpga_valid=1, fpga_data=result[tx_idx].
    - On fpga_valid && fpga_ready, tx_idx increments.
    - On consumption of bit TX_BITS-1, go to RECV.
    - fpga_ready low holds fpga_data and tx_idx stable.
- Opcodes:
  - 00 = A & B
  - 01 = A | B
  - 10 = A ^ B
  - 11 = A + B modulo 2^WIDTH; carry discarded unless the optional feature is enabled.
- Latency: last input bit accepted at edge N → COMPUTE during cycle N..N+1 → fpga_valid high after edge N+1, with bit 0 on fpga_data.
- Timing of fpga_data / fpga_valid: combinational from registered state, tx_idx and result only. No path from pc_data.
- Counter width: $clog2(2+2*WIDTH+1) bits for rx_idx, $clog2(TX_BITS+1) bits for tx_idx. No wrap inside a frame; counters reset to 0 at each frame boundary.
- Back-to-back frames: the first bit of the next frame is accepted on the edge after the final output bit is consumed, i.e. the first cycle back in RECV.
- Reset mid-frame or mid-send: immediate abort. Partial data is discarded and nothing is re-sent.

Optional Feature:
- Macro: OKAND_CARRY_OUT_EN.
- Defined: TX_BITS = WIDTH+1. The extra final bit is the ADD carry-out, or 0 for logic ops.
- Undefined: TX_BITS = WIDTH; carry is not computed or stored.

Test Plan:
- AND, WIDTH=16: opcode 00, A=0xF0F0, B=0xFF00 sent contiguously → fpga_valid rises 2 cycles after last bit; 16 bits LSB first = 0xF000; then pc_ready=1.
- ADD wrap, WIDTH=16, feature off: opcode 11, A=0xFFFF, B=0x0001 → 16 bits = 0x0000.
- ADD wrap, feature on: same frame → 17 bits; first 16 = 0x0000, bit 16 = 1.
- Backpressure: opcode 01, A=0x00FF, B=0x0F00, fpga_ready toggled 1,0,0,1 repeatedly → result 0x0FFF intact; fpga_data stable while fpga_ready=0.
- Input stall / drop:
  - pc_valid low for 5 cycles mid-operand → result unaffected.
  - pc_valid with pc_data=1 during SEND → ignored; the next frame is decoded correctly.
- Reset mid-frame, WIDTH=8 build: assert pc_rst_n=0 after 7 bits → outputs at reset values. Then send opcode 10, A=0xA5, B=0xFF → 8 bits = 0x5A.

Source files
------------

// File: rtl/okand_serial_alu.sv
// Bit-serial ALU for the PC link: receives {B, A, opcode} LSB first, then streams the result back LSB first.
// Build option OKAND_CARRY_OUT_EN appends the ADD carry-out as an extra final result bit.
//
// state   | meaning
// RECV    | accepting frame bits (pc_ready=1)
// COMPUTE | one cycle: result register loaded from opcode/operands
// SEND    | streaming result bits under fpga_ready backpressure
module okand_serial_alu #(
  parameter int WIDTH = 16
) (
  input  logic pc_clk,
  input  logic pc_rst_n,
  input  logic pc_data,
  input  logic pc_valid,
  output logic pc_ready,
  output logic fpga_data,
  output logic fpga_valid,
  input  logic fpga_ready,
  output logic busy
);

  localparam int FRAME_BITS = 2 + 2 * WIDTH;
  localparam int RXW        = $clog2(FRAME_BITS + 1);
`ifdef OKAND_CARRY_OUT_EN
  localparam int TX_BITS    = WIDTH + 1;
`else
  localparam int TX_BITS    = WIDTH;
`endif
  localparam int TXW        = $clog2(TX_BITS + 1);

  localparam logic [RXW-1:0] A_START = RXW'(2);
  localparam logic [RXW-1:0] B_START = RXW'(WIDTH + 2);
  localparam logic [RXW-1:0] RX_LAST = RXW'(FRAME_BITS - 1);
  localparam logic [TXW-1:0] TX_LAST = TXW'(TX_BITS - 1);

  typedef enum logic [1:0] {
    RECV    = 2'd0,
    COMPUTE = 2'd1,
    SEND    = 2'd2
  } state_t;

  state_t             state_q;
  logic [RXW-1:0]     rx_idx_q;
  logic [TXW-1:0]     tx_idx_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [TX_BITS-1:0] result_q;
  logic [TX_BITS-1:0] result_d;
  logic               pc_ready_q;
  logic               fpga_valid_q;
  logic               busy_q;

`ifdef OKAND_CARRY_OUT_EN
  logic [WIDTH:0] sum_ext;
  assign sum_ext = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    result_d = '0;
    unique case (op_q)
      2'b00:   result_d = {1'b0, a_q & b_q};
      2'b01:   result_d = {1'b0, a_q | b_q};
      2'b10:   result_d = {1'b0, a_q ^ b_q};
      default: result_d = sum_ext;
    endcase
  end
`else
  always_comb begin
    result_d = '0;
    unique case (op_q)
      2'b00:   result_d = a_q & b_q;
      2'b01:   result_d = a_q | b_q;
      2'b10:   result_d = a_q ^ b_q;
      default: result_d = a_q + b_q;
    endcase
  end
`endif

  // Operands and result are shift registers: bits arrive and leave LSB first,
  // so no variable bit select is needed on either side.
  always_ff @(posedge pc_clk or negedge pc_rst_n) begin
    if (!pc_rst_n) begin
      state_q      <= RECV;
      rx_idx_q     <= '0;
      tx_idx_q     <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      pc_ready_q   <= 1'b1;
      fpga_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        RECV: begin
          if (pc_valid && pc_ready_q) begin
            if (rx_idx_q < A_START) begin
              op_q <= {pc_data, op_q[1]};
            end else if (rx_idx_q < B_START) begin
              a_q <= {pc_data, a_q[WIDTH-1:1]};
            end else begin
              b_q <= {pc_data, b_q[WIDTH-1:1]};
            end
            if (rx_idx_q == RX_LAST) begin
              rx_idx_q   <= '0;
              state_q    <= COMPUTE;
              pc_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end else begin
              rx_idx_q <= rx_idx_q + RXW'(1);
            end
          end
        end
        COMPUTE: begin
          result_q     <= result_d;
          tx_idx_q     <= '0;
          state_q      <= SEND;
          fpga_valid_q <= 1'b1;
        end
        SEND: begin
          if (fpga_ready) begin
            result_q <= result_q >> 1;
            if (tx_idx_q == TX_LAST) begin
              tx_idx_q     <= '0;
              state_q      <= RECV;
              fpga_valid_q <= 1'b0;
              pc_ready_q   <= 1'b1;
              busy_q       <= 1'b0;
            end else begin
              tx_idx_q <= tx_idx_q + TXW'(1);
            end
          end
        end
        default: begin
          state_q      <= RECV;
          pc_ready_q   <= 1'b1;
          fpga_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign pc_ready   = pc_ready_q;
  assign fpga_valid = fpga_valid_q;
  assign fpga_data  = result_q[0];
  assign busy       = busy_q;

endmodule
